// File: rtl/led_ctrl_pkg.sv
// Shared types and helpers for the LED pattern control block.
package led_ctrl_pkg;

  typedef logic [2:0] mode_t;

  localparam mode_t MODE_SHIFT     = 3'd0;
  localparam mode_t MODE_COUNT     = 3'd1;
  localparam mode_t MODE_FIVES     = 3'd2;
  localparam mode_t MODE_BLINK     = 3'd3;
  localparam mode_t MODE_DOWNCOUNT = 3'd4;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PRESSED   = 2'd1,
    LONG_HELD = 2'd2
  } press_state_t;

  // Next pattern mode, wrapping from the last mode back to the first.
  function automatic mode_t next_mode(input mode_t cur, input mode_t last);
    mode_t nxt;
    if (cur == last) begin
      nxt = MODE_SHIFT;
    end else begin
      nxt = cur + 3'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser followed by a stability-counter debouncer.
// btn_db only follows the synchronised level after it has differed
// from btn_db for DEBOUNCE_CYCLES consecutive cycles.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic i_btn,
  output logic o_btn_db
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_db;
  logic [CNT_W-1:0] r_cnt;

  // Bring the asynchronous button into the clock domain.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= i_btn;
      r_sync2 <= r_sync1;
    end
  end

  // Count cycles of disagreement; accept the new level once it has held long enough.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
      r_db  <= 1'b0;
    end else if (r_sync2 == r_db) begin
      r_cnt <= '0;
    end else if (r_cnt == CNT_LAST) begin
      r_cnt <= '0;
      r_db  <= r_sync2;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_btn_db = r_db;

endmodule

// File: rtl/led_mode_scheduler.sv
// Control block for the 8-LED pattern datapath: debounced button,
// short/long press classification, mode and pause control, tick strobes.
// Optional feature: define AUTO_CYCLE_EN to auto-advance the mode after
// AUTO_CYCLE_SECONDS of idle, unpaused operation.
module led_mode_scheduler
  import led_ctrl_pkg::*;
#(
  parameter int CLK_FREQ           = 25_000_000,
  parameter int DEBOUNCE_CYCLES    = CLK_FREQ / 50,
  parameter int LONG_PRESS_CYCLES  = CLK_FREQ,
  parameter int NUM_MODES          = 5,
  parameter int AUTO_CYCLE_SECONDS = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn,
  output logic [2:0] mode,
  output logic       mode_changed,
  output logic       paused,
  output logic       tick_fast,
  output logic       tick_slow,
  output logic       short_press,
  output logic       long_press
);

  localparam int    HOLD_W    = (LONG_PRESS_CYCLES > 2) ? $clog2(LONG_PRESS_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_PRESS_CYCLES - 1);
  localparam int    TICK_DIV  = CLK_FREQ / 4;
  localparam int    TICK_W    = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
  localparam mode_t MODE_LAST = mode_t'(NUM_MODES - 1);

  logic                w_btn_db;
  press_state_t        r_state;
  press_state_t        w_state_nxt;
  logic [HOLD_W-1:0]   r_hold;
  logic [HOLD_W-1:0]   w_hold_nxt;
  logic                w_short;
  logic                w_long;
  logic                r_short_press;
  logic                r_long_press;
  mode_t               r_mode;
  logic                r_mode_changed;
  logic                r_paused;
  logic                w_auto;
  logic                w_advance;
  logic [TICK_W-1:0]   r_tick_cnt;
  logic                r_phase;
  logic                r_tick_fast;
  logic                r_tick_slow;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn_debounce (
    .clk      (clk),
    .rst      (rst),
    .i_btn    (btn),
    .o_btn_db (w_btn_db)
  );

  // Classifier state, hold counter and registered press pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= IDLE;
      r_hold        <= '0;
      r_short_press <= 1'b0;
      r_long_press  <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_hold        <= w_hold_nxt;
      r_short_press <= w_short;
      r_long_press  <= w_long;
    end
  end

  // Classifier next state: release before the long threshold is a short press.
  always_comb begin
    w_state_nxt = r_state;
    w_hold_nxt  = r_hold;
    w_short     = 1'b0;
    w_long      = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_btn_db) begin
          w_state_nxt = PRESSED;
          w_hold_nxt  = '0;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      PRESSED: begin
        if (!w_btn_db) begin
          w_short     = 1'b1;
          w_state_nxt = IDLE;
        end else if (r_hold == HOLD_LAST) begin
          w_long      = 1'b1;
          w_state_nxt = LONG_HELD;
        end else begin
          w_hold_nxt  = r_hold + HOLD_W'(1);
        end
      end
      LONG_HELD: begin
        if (!w_btn_db) begin
          w_state_nxt = IDLE;
        end else begin
          w_state_nxt = LONG_HELD;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_hold_nxt  = '0;
      end
    endcase
  end

`ifdef AUTO_CYCLE_EN
  localparam int IDLE_TERM = AUTO_CYCLE_SECONDS * CLK_FREQ;
  localparam int IDLE_W    = (IDLE_TERM > 2) ? $clog2(IDLE_TERM) : 1;
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_TERM - 1);

  logic [IDLE_W-1:0] r_idle_cnt;

  assign w_auto = (r_idle_cnt == IDLE_LAST);

  // Idle timer: runs only while unpaused and no press is in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_idle_cnt <= '0;
    end else if (r_paused || r_short_press || r_long_press || w_advance) begin
      r_idle_cnt <= '0;
    end else if (r_state == IDLE) begin
      r_idle_cnt <= r_idle_cnt + IDLE_W'(1);
    end else begin
      r_idle_cnt <= r_idle_cnt;
    end
  end
`else
  logic w_unused_cfg;

  assign w_auto       = 1'b0;
  assign w_unused_cfg = (AUTO_CYCLE_SECONDS > 32'sd0);
`endif

  // A coincident short press and auto-advance collapse into one advance.
  assign w_advance = r_short_press | w_auto;

  // Mode and pause control, one cycle after the press pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mode         <= MODE_SHIFT;
      r_mode_changed <= 1'b0;
      r_paused       <= 1'b0;
    end else begin
      r_mode_changed <= w_advance;
      if (w_advance) begin
        r_mode <= next_mode(r_mode, MODE_LAST);
      end else begin
        r_mode <= r_mode;
      end
      if (r_long_press) begin
        r_paused <= ~r_paused;
      end else begin
        r_paused <= r_paused;
      end
    end
  end

  // Tick strobes: restart on a mode change, freeze while paused.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tick_cnt  <= '0;
      r_phase     <= 1'b0;
      r_tick_fast <= 1'b0;
      r_tick_slow <= 1'b0;
    end else if (w_advance) begin
      r_tick_cnt  <= '0;
      r_phase     <= 1'b0;
      r_tick_fast <= 1'b0;
      r_tick_slow <= 1'b0;
    end else if (r_paused) begin
      r_tick_fast <= 1'b0;
      r_tick_slow <= 1'b0;
    end else if (r_tick_cnt == TICK_LAST) begin
      r_tick_cnt  <= '0;
      r_phase     <= ~r_phase;
      r_tick_fast <= 1'b1;
      r_tick_slow <= r_phase;
    end else begin
      r_tick_cnt  <= r_tick_cnt + TICK_W'(1);
      r_tick_fast <= 1'b0;
      r_tick_slow <= 1'b0;
    end
  end

  assign mode         = r_mode;
  assign mode_changed = r_mode_changed;
  assign paused       = r_paused;
  assign tick_fast    = r_tick_fast;
  assign tick_slow    = r_tick_slow;
  assign short_press  = r_short_press;
  assign long_press   = r_long_press;

endmodule

// File: tb/tb_led_mode_scheduler.sv
// Scoreboard bench for led_mode_scheduler with small simulation parameters.
// Stimulus pushes hand-computed events (cycle stamp + value); a monitor
// pops and compares them whenever the DUT pulses an output.
module tb_led_mode_scheduler;

  typedef struct {
    int cyc;
    int val;
  } ev_t;

  logic       clk;
  logic       rst;
  logic       btn;
  logic [2:0] mode;
  logic       mode_changed;
  logic       paused;
  logic       tick_fast;
  logic       tick_slow;
  logic       short_press;
  logic       long_press;

  int  cyc        = 0;
  int  n_checks   = 0;
  int  n_fail     = 0;
  int  mc_count   = 0;
  bit  tick_strict = 1'b0;

  ev_t press_q[$];
  ev_t mode_q[$];
  ev_t pause_q[$];
  ev_t tick_q[$];

  led_mode_scheduler #(
    .CLK_FREQ          (16),
    .DEBOUNCE_CYCLES   (4),
    .LONG_PRESS_CYCLES (20),
    .NUM_MODES         (5),
    .AUTO_CYCLE_SECONDS(2)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .btn          (btn),
    .mode         (mode),
    .mode_changed (mode_changed),
    .paused       (paused),
    .tick_fast    (tick_fast),
    .tick_slow    (tick_slow),
    .short_press  (short_press),
    .long_press   (long_press)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_unexpected(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: pulse at cycle %0d, expected none", name, cyc);
  endtask

  // Advance to the falling edge at which cyc equals n.
  task automatic at(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  function automatic ev_t ev(input int c, input int v);
    ev_t e;
    e.cyc = c;
    e.val = v;
    return e;
  endfunction

  // Monitor: samples just after each rising edge and pops the scoreboard.
  initial begin : monitor
    ev_t        e;
    logic [2:0] prev_mode;
    logic       prev_paused;
    prev_mode   = 3'd0;
    prev_paused = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        prev_mode   = mode;
        prev_paused = paused;
      end else begin
        if (short_press || long_press) begin
          if (press_q.size() == 0) begin
            fail_unexpected("press_unexpected");
          end else begin
            e = press_q.pop_front();
            check("press_cycle", cyc, e.cyc);
            check("press_kind", int'({long_press, short_press}), e.val);
          end
        end
        if (mode_changed) begin
          mc_count++;
          if (mode_q.size() == 0) begin
            fail_unexpected("mode_changed_unexpected");
          end else begin
            e = mode_q.pop_front();
            check("mode_changed_cycle", cyc, e.cyc);
            check("mode_value", int'(mode), e.val);
          end
        end else if (mode != prev_mode) begin
          fail_unexpected("mode_change_without_pulse");
        end
        if (paused != prev_paused) begin
          if (pause_q.size() == 0) begin
            fail_unexpected("paused_unexpected");
          end else begin
            e = pause_q.pop_front();
            check("paused_cycle", cyc, e.cyc);
            check("paused_value", int'(paused), e.val);
          end
        end
        if (tick_fast) begin
          if (tick_q.size() > 0) begin
            e = tick_q.pop_front();
            check("tick_fast_cycle", cyc, e.cyc);
            check("tick_slow_phase", int'(tick_slow), e.val);
          end else if (tick_strict) begin
            fail_unexpected("tick_fast_unexpected");
          end
        end
        if (tick_slow && !tick_fast) begin
          fail_unexpected("tick_slow_alone");
        end
        prev_mode   = mode;
        prev_paused = paused;
      end
    end
  end

  // Directed stimulus with hand-computed event cycles.
  initial begin : stimulus
    rst = 1'b1;
    btn = 1'b0;

    // Reset: three reset edges, then every output must be low.
    at(3);
    check("reset_outputs",
          int'({mode, mode_changed, paused, tick_fast, tick_slow, short_press, long_press}),
          0);
    rst = 1'b0;

`ifdef AUTO_CYCLE_EN
    // Idle auto-advance every 32 cycles.
    mode_q.push_back(ev(35, 1));
    mode_q.push_back(ev(67, 2));
    // A short press restarts the idle window.
    at(70);
    btn = 1'b1;
    press_q.push_back(ev(83, 1));
    mode_q.push_back(ev(84, 3));
    mode_q.push_back(ev(116, 4));
    at(76);
    btn = 1'b0;
    // Long press pauses; no auto-advance while paused.
    at(120);
    btn = 1'b1;
    press_q.push_back(ev(147, 2));
    pause_q.push_back(ev(148, 1));
    at(160);
    btn = 1'b0;
    at(240);
    check("auto_mode_changed_count", mc_count, 4);
    check("auto_final_mode", int'(mode), 4);
`else
    // Free-running ticks after reset: fast every 4, slow on every 2nd fast.
    tick_strict = 1'b1;
    tick_q.push_back(ev(7, 0));
    tick_q.push_back(ev(11, 1));
    tick_q.push_back(ev(15, 0));
    tick_q.push_back(ev(19, 1));
    at(20);
    tick_strict = 1'b0;
    check("ticks_after_reset_drained", tick_q.size(), 0);

    // Single short press; ticks restart from the mode change.
    btn = 1'b1;
    press_q.push_back(ev(37, 1));
    mode_q.push_back(ev(38, 1));
    at(30);
    btn = 1'b0;
    at(38);
    tick_strict = 1'b1;
    tick_q.push_back(ev(42, 0));
    tick_q.push_back(ev(46, 1));
    at(48);
    tick_strict = 1'b0;
    check("ticks_after_advance_drained", tick_q.size(), 0);

    // Five clean short presses, including the wrap from the last mode.
    for (int i = 0; i < 5; i++) begin
      at(48 + 16 * i);
      btn = 1'b1;
      press_q.push_back(ev(48 + 16 * i + 13, 1));
      mode_q.push_back(ev(48 + 16 * i + 14, (2 + i) % 5));
      at(48 + 16 * i + 6);
      btn = 1'b0;
    end

    // Long press pauses and freezes ticks.
    at(128);
    btn = 1'b1;
    press_q.push_back(ev(155, 2));
    pause_q.push_back(ev(156, 1));
    at(155);
    tick_strict = 1'b1;
    tick_q.push_back(ev(210, 1));
    tick_q.push_back(ev(214, 0));
    tick_q.push_back(ev(218, 1));
    at(168);
    btn = 1'b0;
    // Second long press resumes from the frozen count.
    at(180);
    btn = 1'b1;
    press_q.push_back(ev(207, 2));
    pause_q.push_back(ev(208, 0));
    at(219);
    tick_strict = 1'b0;
    check("ticks_resume_drained", tick_q.size(), 0);
    at(220);
    btn = 1'b0;

    // Bounces shorter than the debounce window are ignored.
    for (int k = 0; k < 10; k++) begin
      at(232 + 2 * k);
      btn = ((k % 2) == 0);
    end
    at(252);
    btn = 1'b0;
    at(275);
    check("bounce_mode_unchanged", int'(mode), 1);

    // Reset during a press discards it; the still-held button is a new press.
    at(280);
    btn = 1'b1;
    at(290);
    rst = 1'b1;
    at(292);
    rst = 1'b0;
    press_q.push_back(ev(307, 1));
    mode_q.push_back(ev(308, 1));
    at(300);
    btn = 1'b0;
    at(320);
    check("mode_changed_count", mc_count, 7);
    check("final_mode", int'(mode), 1);
    check("final_paused", int'(paused), 0);
`endif

    check("press_queue_drained", press_q.size(), 0);
    check("mode_queue_drained", mode_q.size(), 0);
    check("pause_queue_drained", pause_q.size(), 0);
    check("tick_queue_drained", tick_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
